// File: rtl/gate_tt_checker.sv
// Truth-table checker: steps an N_IN-input DUT through every vector, samples its output after a
// settle window and counts mismatches. Optional macro GATE_CHK_STOP_ON_FAIL_EN ends a run at the first mismatch.
module gate_tt_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic [N_IN-1:0]      first_fail_vec,
    output logic                 first_fail_valid
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] LAST_CNT = SW'(SETTLE - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [2**N_IN-1:0]  tbl_q, tbl_d;
    logic [SW-1:0]       cnt_q, cnt_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [N_IN-1:0]     ffv_q, ffv_d;
    logic                ffval_q, ffval_d;
    logic                mism;
    logic                stop;

    always_comb begin
        state_d = state_q;
        tbl_d   = tbl_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffval_d = ffval_q;
        mism    = 1'b0;
        stop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tbl_d   = expected;
                    err_d   = '0;
                    ffv_d   = '0;
                    ffval_d = 1'b0;
                    pass_d  = 1'b0;
                    vec_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    mism  = (dut_out != tbl_q[vec_q]);
                    if (mism) begin
                        if (err_q != '1) err_d = err_q + CNT_W'(1);
                        if (!ffval_q) begin
                            ffv_d   = vec_q;
                            ffval_d = 1'b1;
                        end
                    end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                    stop = mism;
`else
                    stop = 1'b0;
`endif
                    if (vec_q == '1 || stop) begin
                        // vec_out is left on the final (or failing) vector until the next start
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tbl_q   <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= '0;
            ffval_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tbl_q   <= tbl_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffval_q <= ffval_d;
        end
    end

    assign vec_out          = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffval_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: two instances (CNT_W=8 and CNT_W=1) driving 2-input AND gates,
// checked every cycle against a run-level model plus directed literal expectations.
module tb_gate_tt_checker;

    localparam int N      = 2;
    localparam int NV     = 4;
    localparam int SETTLE = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [NV-1:0]  expected = '0;

    logic [N-1:0]   vec_a, ffv_a, vec_b, ffv_b;
    logic           busy_a, done_a, pass_a, ffval_a, dut_a;
    logic           busy_b, done_b, pass_b, ffval_b, dut_b;
    logic [7:0]     err_a;
    logic [0:0]     err_b;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    assign dut_a = &vec_a;
    assign dut_b = &vec_b;

    gate_tt_checker #(.N_IN(N), .SETTLE(SETTLE), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_out(dut_a),
        .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_vec(ffv_a), .first_fail_valid(ffval_a)
    );

    gate_tt_checker #(.N_IN(N), .SETTLE(SETTLE), .CNT_W(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_out(dut_b),
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_vec(ffv_b), .first_fail_valid(ffval_b)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference gate: 2-input AND, so only the all-ones vector yields 1
    function automatic bit gate_ref(input int k);
        return (k == NV - 1);
    endfunction

    // Run-level model: a run is "active" with j cycles elapsed; vector k is judged at j=(k+1)*SETTLE
    bit            m_active = 1'b0;
    bit            m_ran = 1'b0;
    bit            m_done = 1'b0;
    int            m_j = 0;
    bit [NV-1:0]   m_tbl = '0;
    int            nj, kk;
    bit            end_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_ran    <= 1'b0;
            m_done   <= 1'b0;
            m_j      <= 0;
            m_tbl    <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active <= 1'b1;
                    m_j      <= 0;
                    m_tbl    <= expected;
                end
            end else begin
                nj = m_j + 1;
                m_j <= nj;
                if (nj % SETTLE == 0) begin
                    kk = nj / SETTLE - 1;
                    end_run = (kk == NV - 1);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                    if (m_tbl[kk] != gate_ref(kk)) end_run = 1'b1;
`endif
                    if (end_run) begin
                        m_active <= 1'b0;
                        m_ran    <= 1'b1;
                        m_done   <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int m, e, fv, ev;
            bit fval;
            m = m_j / SETTLE;
            e = 0; fv = 0; fval = 1'b0;
            for (int k = 0; k < m; k++) begin
                if (m_tbl[k] != gate_ref(k)) begin
                    e++;
                    if (!fval) begin
                        fv = k;
                        fval = 1'b1;
                    end
                end
            end
            ev = m_active ? m : (m_ran ? m - 1 : 0);
            check("vec_out", int'(vec_a), ev);
            check("busy", int'(busy_a), int'(m_active));
            check("done", int'(done_a), int'(m_done));
            check("pass", int'(pass_a), int'(!m_active && m_ran && e == 0));
            check("err_count", int'(err_a), (e > 255) ? 255 : e);
            check("first_fail_vec", int'(ffv_a), fv);
            check("first_fail_valid", int'(ffval_a), int'(fval));
            check("sat_err_count", int'(err_b), (e > 1) ? 1 : e);
            check("sat_pass", int'(pass_b), int'(!m_active && m_ran && e == 0));
            check("sat_done", int'(done_b), int'(m_done));
        end
    end

    // Launch a run and count negedges until done is seen (9 for a full run started this way)
    task automatic run(input logic [NV-1:0] e, output int n);
        start = 1'b1;
        expected = e;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (done_a) break;
            if (n > 200) begin
                check("done_timeout", n, -1);
                break;
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (done_a) break;
            if (n > 200) begin
                check("done_timeout", n, -1);
                break;
            end
        end
    endtask

    int n;
    bit saw_done;
    logic [NV-1:0] tbls [3];

    initial begin
        repeat (2) @(negedge clk);
        check("rst_vec", int'(vec_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_pass", int'(pass_a), 0);
        check("rst_err", int'(err_a), 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // AND table: clean pass
        run(4'b1000, n);
        check("and_latency", n, 9);
        check("and_pass", int'(pass_a), 1);
        check("and_err", int'(err_a), 0);
        check("and_ffval", int'(ffval_a), 0);
        check("and_vec_end", int'(vec_a), 3);
        @(negedge clk);

        // OR table against AND gate: vectors 1 and 2 mismatch
        run(4'b1110, n);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        check("or_latency", n, 5);
        check("or_err", int'(err_a), 1);
        check("or_vec_end", int'(vec_a), 1);
`else
        check("or_latency", n, 9);
        check("or_err", int'(err_a), 2);
        check("or_vec_end", int'(vec_a), 3);
`endif
        check("or_ffv", int'(ffv_a), 1);
        check("or_ffval", int'(ffval_a), 1);
        check("or_pass", int'(pass_a), 0);
        @(negedge clk);

        // Every vector wrong: narrow counter saturates
        run(4'b0111, n);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        check("all_err", int'(err_a), 1);
`else
        check("all_err", int'(err_a), 4);
`endif
        check("sat_err", int'(err_b), 1);
        check("sat_pass_lit", int'(pass_b), 0);
        check("sat_ffv", int'(ffv_b), 0);
        @(negedge clk);

        // Mid-run start pulse and table change are ignored
        start = 1'b1;
        expected = 4'b1000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        expected = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("midrun_latency", n + 4, 9);
        check("midrun_pass", int'(pass_a), 1);
        @(negedge clk);

        // Asynchronous reset mid-run
        start = 1'b1;
        expected = 4'b1110;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_vec", int'(vec_a), 0);
        check("abort_busy", int'(busy_a), 0);
        check("abort_err", int'(err_a), 0);
        check("abort_ffval", int'(ffval_a), 0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_a) saw_done = 1'b1;
        end
        check("abort_no_done", int'(saw_done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run(4'b1000, n);
        check("post_rst_latency", n, 9);
        check("post_rst_pass", int'(pass_a), 1);
        @(negedge clk);

        // start held high: back-to-back runs, each with its own table
        tbls[0] = 4'b1000;
        tbls[1] = 4'b1110;
        tbls[2] = 4'b1000;
        start = 1'b1;
        expected = tbls[0];
        for (int r = 0; r < 3; r++) begin
            wait_done(n);
            check("b2b_pass", int'(pass_a), (tbls[r] == 4'b1000) ? 1 : 0);
            if (r < 2) expected = tbls[r + 1];
            @(negedge clk);
            check("b2b_restart_busy", int'(busy_a), 1);
            check("b2b_restart_vec", int'(vec_a), 0);
        end
        start = 1'b0;
        wait_done(n);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Self-checking response side for small combinational gate experiments.
- On `start`, the block drives every input vector of an N-input gate under test and holds each one for a settle window.
- At the end of each window it samples the gate output and compares it against a programmable truth table.
- It reports a mismatch count, the first failing vector, and a pass/done result. It sits between a lab top-level and any N-input, 1-output combinational DUT.

Parameters:
- N_IN, 2, number of DUT inputs; 2**N_IN vectors are applied (legal 1..6).
- SETTLE, 2, clock cycles each vector is held before sampling (legal >= 1).
- CNT_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a check run; honoured only in IDLE
- expected  input  2**N_IN  truth table; bit i = expected DUT output for vector i; latched on accepted start
- dut_out  input  1  DUT output, sampled at the end of each settle window
- vec_out  output  N_IN  vector driven to DUT inputs (MSB = first input)
- busy  output  1  run in progress
- done  output  1  one-cycle pulse when a run ends
- pass  output  1  result of the last run: 1 = zero mismatches
- err_count  output  CNT_W  mismatches in the current or last run, saturating
- first_fail_vec  output  N_IN  vector index of the first mismatch
- first_fail_valid  output  1  first_fail_vec holds a valid index

Behaviour:
- Reset (async assert, sync release): state=IDLE; vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0; latched table cleared.
- All outputs are registered. Only `start`, `expected` and `dut_out` are sampled.
- States:
  - IDLE: at an edge with start=1, latch expected, clear err_count/first_fail_*/pass, set vec_out=0, busy=1, settle counter=0, go HOLD.
  - HOLD: the settle counter increments each edge. At the edge where counter==SETTLE-1 (the compare edge), compare dut_out with table[vec_out].
    - Mismatch: err_count+1, saturating at 2**CNT_W-1. If first_fail_valid=0, load first_fail_vec=vec_out and set first_fail_valid=1.
    - Not the last vector: vec_out+1, counter=0, stay in HOLD.
    - Last vector (vec_out == 2**N_IN-1): go IDLE, busy=0, done=1. pass=1 iff the total mismatches including this compare is 0.
- Timing: with start accepted at edge E0, vector k is compared at edge E0+(k+1)*SETTLE. done is high for exactly the cycle following edge E0+(2**N_IN)*SETTLE. err_count, pass and first_fail_* are final in that cycle.
- done is cleared at the next edge. If start=1 in that same cycle, a new run is accepted at that edge.
- vec_out holds its last value (all ones) after a run until the next start.
- start while busy: ignored, no effect.
- Changes on `expected` mid-run: ignored; the latched copy is used.
- Counter wrap: vec_out never wraps mid-run; the run terminates on the last vector.
- rst_n asserted mid-run: immediate abort to reset values; no done pulse.

Optional Feature:
- Macro: GATE_CHK_STOP_ON_FAIL_EN
- Defined: the first mismatch ends the run at that compare edge. busy=0, done=1, pass=0, err_count=1, first_fail_* loaded, vec_out holds the failing vector.
- Undefined: the run always covers all 2**N_IN vectors, as described in Behaviour.

Test Plan:
- AND DUT, N_IN=2, SETTLE=2, expected=4'b1000:
  - vec_out steps 0,1,2,3, each held 2 cycles.
  - done one cycle after edge E0+8.
  - pass=1, err_count=0, first_fail_valid=0.
- AND DUT, expected=4'b1110 (OR table):
  - err_count=2, first_fail_vec=2'b01, first_fail_valid=1, pass=0.
  - With GATE_CHK_STOP_ON_FAIL_EN defined: done after edge E0+4, err_count=1, vec_out=2'b01.
- CNT_W=1, AND DUT, expected=4'b0111 (every vector wrong): err_count saturates at 1, pass=0, first_fail_vec=0.
- start pulsed again at cycle 3 of a run, and expected changed mid-run: no restart, done still after E0+8, results match the original latched table.
- rst_n low at cycle 5 of a run: all outputs 0 immediately, no done. A new start after release runs a full clean sequence with correct results.
- start held high continuously: back-to-back runs; each done pulse is followed by vec_out=0 and busy=1 in the next cycle, and each run's results are independent.
